// File: rtl/multi_wave_generator_if.sv
// Bundles the configuration, commit and sample-stream signals
// of multi_wave_generator.
interface multi_wave_generator_if #(
    parameter int CH = 4,
    parameter int N  = 32,
    parameter int M  = 16
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    logic            cfg_wr;
    logic [CW-1:0]   cfg_ch;
    logic [1:0]      cfg_reg;
    logic [N-1:0]    cfg_data;
    logic            commit;
    logic            sample_en;
    logic            commit_pending;
    logic [CH*M-1:0] wave_out;
    logic            wave_valid;

    modport master (
        output cfg_wr, cfg_ch, cfg_reg, cfg_data,
        output commit, sample_en,
        input  commit_pending, wave_out, wave_valid
    );

    modport slave (
        input  cfg_wr, cfg_ch, cfg_reg, cfg_data,
        input  commit, sample_en,
        output commit_pending, wave_out, wave_valid
    );
endinterface

// File: rtl/multi_wave_generator.sv
// CH-channel DDS waveform generator with shadow configuration
// registers committed atomically on a sample strobe.
module multi_wave_generator #(
    parameter int CH = 4,
    parameter int N  = 32,
    parameter int M  = 16
) (
    input logic                  clk,
    input logic                  rst,
    multi_wave_generator_if.slave bus
);
    typedef logic [N-1:0] word_t;
    typedef logic [7:0]   ctrl_t;

    word_t sh_freq_q [CH], sh_freq_d [CH];
    word_t sh_off_q  [CH], sh_off_d  [CH];
    word_t sh_duty_q [CH], sh_duty_d [CH];
    ctrl_t sh_ctrl_q [CH], sh_ctrl_d [CH];
    word_t act_freq_q[CH], act_freq_d[CH];
    word_t act_off_q [CH], act_off_d [CH];
    word_t act_duty_q[CH], act_duty_d[CH];
    ctrl_t act_ctrl_q[CH], act_ctrl_d[CH];
    word_t acc_q     [CH], acc_d     [CH];
    logic [31:0] lfsr_q[CH], lfsr_d[CH];

    logic            pend_q, pend_d;
    logic            vld_q, vld_d;
    logic            valid_q, valid_d;
    logic [CH*M-1:0] wave_q, wave_d;
    logic            xfer;
    logic            wr_ok;

    function automatic logic [31:0] lfsr_step(logic [31:0] l);
        return {1'b0, l[31:1]} ^ (l[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [M-1:0] shape(
        word_t acc, word_t off, word_t duty,
        ctrl_t ctrl, logic [31:0] lfsr
    );
        word_t        p;
        logic [M-1:0] u;
        logic [M-1:0] t;
        logic [M-1:0] o;
        p = acc + off;
        u = p[N-1 -: M];
        t = p[N-2 -: M];
        if (p[N-1]) t = ~t;
        unique case (ctrl[2:1])
            2'd0: o = {~u[M-1], u[M-2:0]};
            2'd1: o = {~t[M-1], t[M-2:0]};
            2'd2: o = (p < duty) ? {1'b0, {(M-1){1'b1}}}
                                 : {1'b1, {(M-1){1'b0}}};
            default: o = lfsr[31 -: M];
        endcase
        o = $signed(o) >>> ctrl[6:3];
        return ctrl[0] ? o : '0;
    endfunction

    assign xfer  = bus.sample_en & (pend_q | bus.commit);
    assign wr_ok = bus.cfg_wr & (int'(bus.cfg_ch) < CH);

    always_comb begin
        sh_freq_d  = sh_freq_q;
        sh_off_d   = sh_off_q;
        sh_duty_d  = sh_duty_q;
        sh_ctrl_d  = sh_ctrl_q;
        act_freq_d = act_freq_q;
        act_off_d  = act_off_q;
        act_duty_d = act_duty_q;
        act_ctrl_d = act_ctrl_q;
        acc_d      = acc_q;
        lfsr_d     = lfsr_q;
        wave_d     = wave_q;
        pend_d     = xfer ? 1'b0 : (pend_q | bus.commit);
        vld_d      = bus.sample_en;
        valid_d    = vld_q;

        // A transfer edge steps with the freshly committed frequency.
        for (int c = 0; c < CH; c++) begin
            if (bus.sample_en) begin
                lfsr_d[c] = lfsr_step(lfsr_q[c]);
                if (xfer && sh_ctrl_q[c][7])
                    acc_d[c] = sh_freq_q[c];
                else
                    acc_d[c] = acc_q[c] +
                        (xfer ? sh_freq_q[c] : act_freq_q[c]);
            end
            if (xfer) begin
                act_freq_d[c] = sh_freq_q[c];
                act_off_d[c]  = sh_off_q[c];
                act_duty_d[c] = sh_duty_q[c];
                act_ctrl_d[c] = sh_ctrl_q[c];
            end
            if (vld_q)
                wave_d[c*M +: M] = shape(acc_q[c], act_off_q[c],
                    act_duty_q[c], act_ctrl_q[c], lfsr_q[c]);
        end

        if (wr_ok) begin
            unique case (bus.cfg_reg)
                2'd0: sh_freq_d[bus.cfg_ch] = bus.cfg_data;
                2'd1: sh_off_d[bus.cfg_ch]  = bus.cfg_data;
                2'd2: sh_duty_d[bus.cfg_ch] = bus.cfg_data;
                default: sh_ctrl_d[bus.cfg_ch] = bus.cfg_data[7:0];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CH; c++) begin
                sh_freq_q[c]  <= '0;
                sh_off_q[c]   <= '0;
                sh_duty_q[c]  <= '0;
                sh_ctrl_q[c]  <= '0;
                act_freq_q[c] <= '0;
                act_off_q[c]  <= '0;
                act_duty_q[c] <= '0;
                act_ctrl_q[c] <= '0;
                acc_q[c]      <= '0;
                lfsr_q[c]     <= 32'hACE1_0000 + 32'(c);
            end
            pend_q  <= 1'b0;
            vld_q   <= 1'b0;
            valid_q <= 1'b0;
            wave_q  <= '0;
        end else begin
            sh_freq_q  <= sh_freq_d;
            sh_off_q   <= sh_off_d;
            sh_duty_q  <= sh_duty_d;
            sh_ctrl_q  <= sh_ctrl_d;
            act_freq_q <= act_freq_d;
            act_off_q  <= act_off_d;
            act_duty_q <= act_duty_d;
            act_ctrl_q <= act_ctrl_d;
            acc_q      <= acc_d;
            lfsr_q     <= lfsr_d;
            pend_q     <= pend_d;
            vld_q      <= vld_d;
            valid_q    <= valid_d;
            wave_q     <= wave_d;
        end
    end

    assign bus.commit_pending = pend_q;
    assign bus.wave_out       = wave_q;
    assign bus.wave_valid     = valid_q;
endmodule

// File: tb/tb_multi_wave_generator.sv
// Scoreboard bench for multi_wave_generator: a behavioural model
// predicts every sample, a monitor checks value and timing.
module tb_multi_wave_generator;
  localparam int CH = 4;
  localparam int N  = 32;
  localparam int M  = 16;

  typedef struct {
    int              due;
    logic [CH*M-1:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_wave_generator_if #(.CH(CH), .N(N), .M(M)) bus();

  multi_wave_generator #(.CH(CH), .N(N), .M(M)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int edge_n = 0;
  exp_t q[$];

  logic [31:0] s_freq[CH], s_off[CH], s_duty[CH], s_ctrl[CH];
  logic [31:0] a_freq[CH], a_off[CH], a_duty[CH], a_ctrl[CH];
  logic [31:0] m_acc[CH], m_lfsr[CH];
  bit m_pend;

  always @(posedge clk) edge_n++;

  function automatic logic [15:0] ref_out(int c);
    logic [31:0] p;
    int v;
    int t;
    p = m_acc[c] + a_off[c];
    case (a_ctrl[c][2:1])
      2'd0: v = int'(p >> 16) - 32768;
      2'd1: begin
        t = int'((p >> 15) & 32'hFFFF);
        if (p[31]) t = 65535 - t;
        v = t - 32768;
      end
      2'd2: v = (p < a_duty[c]) ? 32767 : -32768;
      default: begin
        v = int'(m_lfsr[c] >> 16);
        if (v >= 32768) v -= 65536;
      end
    endcase
    v = v >>> a_ctrl[c][6:3];
    if (!a_ctrl[c][0]) v = 0;
    return 16'(v);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      s_freq[c] = 0; s_off[c] = 0; s_duty[c] = 0; s_ctrl[c] = 0;
      a_freq[c] = 0; a_off[c] = 0; a_duty[c] = 0; a_ctrl[c] = 0;
      m_acc[c] = 0;
      m_lfsr[c] = 32'hACE1_0000 + 32'(c);
    end
    m_pend = 0;
    q.delete();
  endtask

  task automatic step(input bit wr, input int ch, input int rg,
                      input logic [31:0] d, input bit cm, input bit se);
    bit xfer;
    exp_t e;
    bus.cfg_wr = wr;
    bus.cfg_ch = 2'(ch);
    bus.cfg_reg = 2'(rg);
    bus.cfg_data = d;
    bus.commit = cm;
    bus.sample_en = se;
    @(posedge clk);
    #1;
    xfer = (m_pend || cm) && se;
    if (se) begin
      for (int c = 0; c < CH; c++) begin
        if (xfer && s_ctrl[c][7]) m_acc[c] = s_freq[c];
        else m_acc[c] = m_acc[c] + (xfer ? s_freq[c] : a_freq[c]);
        m_lfsr[c] = m_lfsr[c][0] ? ((m_lfsr[c] >> 1) ^ 32'h8020_0003)
                                 : (m_lfsr[c] >> 1);
      end
    end
    if (xfer) begin
      a_freq = s_freq; a_off = s_off; a_duty = s_duty; a_ctrl = s_ctrl;
      m_pend = 0;
    end else if (cm) begin
      m_pend = 1;
    end
    if (wr) begin
      case (rg)
        0: s_freq[ch] = d;
        1: s_off[ch] = d;
        2: s_duty[ch] = d;
        default: s_ctrl[ch] = d & 32'hFF;
      endcase
    end
    if (se) begin
      e.due = edge_n + 1;
      for (int c = 0; c < CH; c++) e.v[c*M +: M] = ref_out(c);
      q.push_back(e);
    end
    tests++;
    if (bus.commit_pending !== m_pend) begin
      fails++;
      $display("FAIL commit_pending: got %b want %b", bus.commit_pending, m_pend);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  function automatic logic [15:0] chv(int c);
    return bus.wave_out[c*M +: M];
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst === 1'b1) begin
      if (bus.wave_valid === 1'b1) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_valid: got wave_out %h, want no valid", bus.wave_out);
        end else begin
          e = q.pop_front();
          if (e.v !== bus.wave_out || e.due != edge_n) begin
            fails++;
            $display("FAIL sample: got %h at edge %0d, want %h at edge %0d",
                     bus.wave_out, edge_n, e.v, e.due);
          end
        end
      end else if (q.size() > 0 && q[0].due <= edge_n) begin
        tests++;
        fails++;
        e = q.pop_front();
        $display("FAIL missing_valid: got none at edge %0d, want %h", edge_n, e.v);
      end
    end
  end

  logic [15:0] prev, cur, exp16;

  initial begin
    rst = 1'b0;
    bus.cfg_wr = 0; bus.cfg_ch = 0; bus.cfg_reg = 0; bus.cfg_data = 0;
    bus.commit = 0; bus.sample_en = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk("reset_wave_out", 32'(bus.wave_out), 0);
    chk("reset_wave_valid", 32'(bus.wave_valid), 0);
    chk("reset_pending", 32'(bus.commit_pending), 0);

    // sawtooth on ch0
    step(1, 0, 0, 32'h1000_0000, 0, 0);
    step(1, 0, 3, 32'h1, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    chk("t1_no_pending", 32'(bus.commit_pending), 0);
    for (int i = 1; i <= 17; i++) begin
      step(0, 0, 0, 0, 0, 1);
      exp16 = 16'(i * 4096) ^ 16'h8000;
      chk("t1_saw_ch0", 32'(chv(0)), 32'(exp16));
      if (i == 5) chk("t1_ch1_zero", 32'(chv(1)), 0);
    end

    // pulse
    step(1, 0, 2, 32'h4000_0000, 0, 0);
    step(1, 0, 3, 32'h85, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 0, 0, 0, 1);
      exp16 = ((i % 16) < 4) ? 16'h7FFF : 16'h8000;
      chk("t2_pulse", 32'(chv(0)), 32'(exp16));
    end
    step(1, 0, 2, 32'h0, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 1);
      chk("t2_duty0", 32'(chv(0)), 32'h8000);
    end

    // triangle with amplitude shift
    step(1, 0, 0, 32'h2000_0000, 0, 0);
    step(1, 0, 3, 32'h8B, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 0, 0, 0, 1);
      if (i == 1) chk("t3_first", 32'(chv(0)), 32'hE000);
      if (i == 4) chk("t3_peak", 32'(chv(0)), 32'h3FFF);
    end

    // shadow isolation and deferred commit
    step(1, 0, 0, 32'h1000_0000, 0, 0);
    step(1, 0, 3, 32'h81, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 32'h0800_0000, 0, 1);
    prev = chv(0);
    step(0, 0, 0, 0, 0, 1);
    cur = chv(0);
    chk("t4_step_unchanged", 32'(16'(cur - prev)), 32'h1000);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t4_pending_high", 32'(bus.commit_pending), 1);
      step(0, 0, 0, 0, 0, 0);
    end
    chk("t4_pending_high", 32'(bus.commit_pending), 1);
    step(1, 0, 0, 32'h0400_0000, 0, 1);
    chk("t4_pending_clear", 32'(bus.commit_pending), 0);
    step(0, 0, 0, 0, 0, 1);
    prev = chv(0);
    step(0, 0, 0, 0, 0, 1);
    cur = chv(0);
    chk("t4_new_step", 32'(16'(cur - prev)), 32'h0800);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1);
    prev = chv(0);
    step(0, 0, 0, 0, 0, 1);
    cur = chv(0);
    chk("t4_shadow_step", 32'(16'(cur - prev)), 32'h0400);

    // phase-aligned channels
    step(1, 0, 0, 32'h1000_0000, 0, 0);
    step(1, 1, 0, 32'h1000_0000, 0, 0);
    step(1, 1, 1, 32'h4000_0000, 0, 0);
    step(1, 0, 3, 32'h81, 0, 0);
    step(1, 1, 3, 32'h81, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("t5_ch0_first", 32'(chv(0)), 32'h9000);
    chk("t5_ch1_first", 32'(chv(1)), 32'hD000);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 0, 1);
      chk("t5_lead", 32'(16'(chv(1) - chv(0))), 32'h4000);
    end

    // randomized traffic
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 2) == 0), $urandom_range(0, CH-1),
           $urandom_range(0, 3), $urandom(),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1));
    idle(3);

    // asynchronous reset mid-stream
    step(1, 2, 3, 32'h07, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    #2 rst = 1'b0;
    #1;
    chk("t6_wave_out", 32'(bus.wave_out), 0);
    chk("t6_wave_valid", 32'(bus.wave_valid), 0);
    chk("t6_pending", 32'(bus.commit_pending), 0);
    model_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);
      chk("t6_zero_out", 32'(bus.wave_out), 0);
    end
    idle(3);
    chk("queue_drained", 32'(q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
